// File: rtl/multi_mode_crossover.sv
// multi_mode_crossover: two-stage GA crossover engine with LFSR-driven masks and rate gating
module multi_mode_crossover #(
  parameter int IndividualWidth = 8,
  parameter int IdxWidth = $clog2(IndividualWidth),
  parameter int LfsrWidth = 64,
  parameter logic [LfsrWidth-1:0] LfsrTaps = 64'hD800_0000_0000_0000,
  parameter logic [LfsrWidth-1:0] Seed = 64'h1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       seed_load,
  input  logic [LfsrWidth-1:0]       seed_val,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 mode,
  input  logic [8:0]                 rate,
  input  logic [IndividualWidth-1:0] dad,
  input  logic [IndividualWidth-1:0] mom,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IndividualWidth-1:0] son,
  output logic [IndividualWidth-1:0] daughter,
  output logic [IndividualWidth-1:0] mask,
  output logic                       crossed
);
  localparam int W = IndividualWidth;
  logic [LfsrWidth-1:0] lfsr;
  logic s1_valid;
  logic [W-1:0] s1_dad, s1_mom, s1_lo;
  logic [7:0] s1_r8;
  logic [1:0] s1_mode;
  logic [8:0] s1_rate;
  logic s2_load, accept;
  logic [IdxWidth-1:0] a, b, lo, hi;
  logic [W-1:0] ones, span, nmask;
  assign s2_load = !out_valid || out_ready;
  assign in_ready = ce && (!s1_valid || s2_load);
  assign accept = in_valid && in_ready;
  always_comb begin
    a = s1_lo[IdxWidth-1:0];
    b = s1_lo[2*IdxWidth-1:IdxWidth];
    lo = a < b ? a : b;
    hi = a < b ? b : a;
    ones = '1;
    span = (ones << lo) & ~(ones << hi);
    nmask = !({1'b0, s1_r8} < s1_rate) ? '0 :
            s1_mode == 2'd0 ? ones << a :
            s1_mode == 2'd1 ? span :
            s1_mode == 2'd2 ? s1_lo : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= Seed;
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      son <= '0;
      daughter <= '0;
      mask <= '0;
      crossed <= 1'b0;
    end else if (ce) begin
      lfsr <= seed_load ? (seed_val == '0 ? Seed : seed_val) :
              accept ? (lfsr >> 1) ^ (lfsr[0] ? LfsrTaps : '0) : lfsr;
      if (in_ready)
        s1_valid <= in_valid;
      if (accept) begin
        s1_dad <= dad;
        s1_mom <= mom;
        s1_mode <= mode;
        s1_rate <= rate;
        s1_lo <= lfsr[W-1:0];
        s1_r8 <= lfsr[LfsrWidth-1:LfsrWidth-8];
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          son <= (s1_dad & ~nmask) | (s1_mom & nmask);
          daughter <= (s1_dad & nmask) | (s1_mom & ~nmask);
          mask <= nmask;
          crossed <= |nmask;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_mode_crossover.sv
// tb_multi_mode_crossover: randomized and directed checks against a queue-based reference model
module tb_multi_mode_crossover;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED = 64'h1;
  logic clk = 0, rst = 1, ce = 1, seed_load = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, crossed;
  logic [63:0] seed_val = 0;
  logic [1:0] mode = 0;
  logic [8:0] rate = 0;
  logic [7:0] dad = 0, mom = 0, son, daughter, mask;
  int checks = 0, passes = 0, tick = 0;
  bit mon_en = 0;
  typedef struct {
    logic [7:0] d, m;
    logic [1:0] md;
    logic [8:0] rt;
    logic [63:0] s;
    int tag;
  } pair_t;
  pair_t q[$];
  logic [63:0] lfsr_m = SEED;

  multi_mode_crossover dut (
    .clk(clk), .rst(rst), .ce(ce), .seed_load(seed_load), .seed_val(seed_val),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .rate(rate),
    .dad(dad), .mom(mom), .out_valid(out_valid), .out_ready(out_ready),
    .son(son), .daughter(daughter), .mask(mask), .crossed(crossed)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 64'h0);
  endfunction

  function automatic logic [7:0] mk(input logic [1:0] md, input logic [63:0] s, input logic [8:0] rt);
    int p, b, lo, hi;
    logic [7:0] m;
    p = int'(s[2:0]);
    b = int'(s[5:3]);
    lo = p < b ? p : b;
    hi = p < b ? b : p;
    for (int i = 0; i < 8; i++)
      m[i] = md == 2'd0 ? i >= p : md == 2'd1 ? (i >= lo && i < hi) : md == 2'd2 ? s[i] : 1'b0;
    return int'(s[63:56]) < int'(rt) ? m : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] m, input logic [1:0] md, input logic [8:0] rt);
    int n = 0;
    dad = d; mom = m; mode = md; rate = rt; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n == 100) chk("send_timeout", 64'(in_ready), 64'(1));
    cyc();
  endtask

  always @(negedge clk) begin
    int sz;
    bit exp_ov;
    pair_t f;
    logic [7:0] em;
    if (mon_en) begin
      sz = q.size();
      exp_ov = 0;
      if (sz > 0) exp_ov = tick >= q[0].tag + 2;
      chk("in_ready", 64'(in_ready), 64'(ce && (sz < 2 || out_ready)));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (out_valid && exp_ov) begin
        f = q[0];
        em = mk(f.md, f.s, f.rt);
        chk("mask", 64'(mask), 64'(em));
        chk("son", 64'(son), 64'((f.d & ~em) | (f.m & em)));
        chk("daughter", 64'(daughter), 64'((f.d & em) | (f.m & ~em)));
        chk("crossed", 64'(crossed), 64'(em != 0));
      end
      if (rst) begin
        q.delete();
        lfsr_m = SEED;
      end else if (ce) begin
        if (out_valid && out_ready && sz > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back('{dad, mom, mode, rate, lfsr_m, tick});
        if (seed_load) lfsr_m = seed_val == 0 ? SEED : seed_val;
        else if (in_valid && in_ready) lfsr_m = step(lfsr_m);
        tick++;
      end
    end
  end

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_son", 64'(son), 64'(0));
    chk("rst_daughter", 64'(daughter), 64'(0));
    chk("rst_mask", 64'(mask), 64'(0));
    chk("rst_crossed", 64'(crossed), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("pin_single", 64'(mk(2'd0, 64'h3, 9'd256)), 64'hF8);
    chk("pin_two", 64'(mk(2'd1, 64'h62, 9'd256)), 64'h0C);
    chk("pin_rate0", 64'(mk(2'd0, 64'h3, 9'd0)), 64'h00);
    chk("pin_uniform", 64'(mk(2'd2, 64'hA5, 9'd256)), 64'hA5);
    chk("pin_step", step(64'h1), 64'hD800_0000_0000_0000);
    cyc();
    send(8'hA5, 8'h5A, 2'd3, 9'd256);
    in_valid = 0;
    @(negedge clk);
    chk("lat_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("pass_son", 64'(son), 64'hA5);
    chk("pass_daughter", 64'(daughter), 64'h5A);
    chk("pass_crossed", 64'(crossed), 64'(0));
    cyc();
    seed_load = 1; seed_val = 64'h3;
    cyc();
    seed_load = 0;
    send(8'hFF, 8'h00, 2'd0, 9'd256);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("sp_mask", 64'(mask), 64'hF8);
    chk("sp_daughter", 64'(daughter), 64'hF8);
    chk("sp_son", 64'(son), 64'h07);
    chk("sp_crossed", 64'(crossed), 64'(1));
    cyc();
    seed_load = 1; seed_val = 64'h62;
    cyc();
    seed_load = 0;
    send(8'hFF, 8'h00, 2'd1, 9'd256);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("tp_mask", 64'(mask), 64'h0C);
    chk("tp_daughter", 64'(daughter), 64'h0C);
    chk("tp_son", 64'(son), 64'hF3);
    cyc();
    repeat (16) send(8'($urandom), 8'($urandom), 2'd0, 9'd0);
    repeat (16) send(8'($urandom), 8'($urandom), 2'd0, 9'd256);
    in_valid = 0;
    repeat (4) cyc();
    out_ready = 0;
    fork
      repeat (6) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 9'd256);
      begin
        repeat (5) cyc();
        out_ready = 1;
      end
    join
    in_valid = 0;
    repeat (4) cyc();
    out_ready = 0;
    repeat (2) send(8'($urandom), 8'($urandom), 2'd2, 9'd256);
    in_valid = 0;
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_flight_valid", 64'(out_valid), 64'(0));
    chk("rst_flight_ready", 64'(in_ready), 64'(1));
    cyc();
    out_ready = 1;
    send(8'hFF, 8'h00, 2'd0, 9'd256);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("seed_after_rst", 64'(mask), 64'hFE);
    cyc();
    out_ready = 0;
    send(8'h3C, 8'hC3, 2'd2, 9'd256);
    in_valid = 0;
    repeat (2) cyc();
    ce = 0; out_ready = 1; in_valid = 1;
    repeat (3) cyc();
    ce = 1; in_valid = 0;
    repeat (3) cyc();
    repeat (600) begin
      in_valid = $urandom_range(0, 3) != 0;
      dad = 8'($urandom);
      mom = 8'($urandom);
      mode = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3));
      rate = r == 0 ? 9'd0 : r == 1 ? 9'd256 : 9'($urandom_range(0, 256));
      ce = $urandom_range(0, 9) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      seed_load = $urandom_range(0, 31) == 0;
      seed_val = $urandom_range(0, 3) == 0 ? 64'h0 : {$urandom, $urandom};
      rst = $urandom_range(0, 99) == 0;
      cyc();
    end
    in_valid = 0; ce = 1; out_ready = 1; seed_load = 0; rst = 0;
    repeat (5) cyc();
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'(0));
    chk("drain_valid", 64'(out_valid), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
